write_push_sequencer: RTL and testbench
=======================================

# write_push_sequencer

Sequences multi-word stack pushes for far CALL, INT, exception entry and stack-switch microcode in the write stage. It walks a stack offset downward one push at a time and drives the combinational stack-check block (offset, length select, fault-check strobes). It samples that block's linear address and fault outputs and issues one memory write per push over a request/done handshake. It reports completion or an SS fault to the write-stage controller.

## Interface
Parameters:
- MAX_PUSH, 6, maximum pushes per sequence; `start_count` is clamped to this value.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin sequence; sampled only in IDLE
- `start_count`  in  3  number of pushes, 0..MAX_PUSH
- `start_offset`  in  32  initial ESP
- `start_size_16`  in  1  1: 2-byte pushes, 0: 4-byte pushes
- `start_stack_32`  in  1  SS D/B of the target stack; 0 means 16-bit offset wrap
- `start_new_stack`  in  1  use new-stack linear address and fault inputs
- `abort`  in  1  cancel sequence (pipeline flush)
- `push_index`  out  3  index of the current push; the requester drives `push_data` from it
- `push_data`  in  32  data for `push_index`
- `stack_offset`  out  32  drives `wr_stack_offset` of the stack-check block
- `push_length_word` / `push_length_dword`  out  1 each  length select (exactly one is high)
- `push_ss_fault_check` / `new_push_ss_fault_check`  out  1 each  fault-check strobes
- `push_linear` / `new_push_linear`  in  32 each  linear addresses from the stack-check block
- `push_ss_fault` / `new_push_ss_fault`  in  1 each  fault results
- `mem_write_do`  out  1  write request
- `mem_write_address`  out  32  write address
- `mem_write_data`  out  32  write data
- `mem_write_length`  out  3  2 or 4
- `mem_write_done`  in  1  write accepted/completed
- `busy`  out  1  not IDLE
- `done`  out  1  one-cycle completion pulse
- `fault`  out  1  one-cycle SS-fault pulse
- `final_offset`  out  32  ESP after the last successful sequence

## Operation
States: IDLE, CHECK, WRITE.

Length and offset arithmetic:
- len = 2 if `start_size_16`, else 4.
- dec(x) = x − len when `start_stack_32`=1.
- dec(x) = {x[31:16], x[15:0] − len} when `start_stack_32`=0, so the low 16 bits wrap and the high half is preserved.

State behaviour:
- **IDLE**, on `start`:
  - count==0: pulse `done`, `final_offset` = `start_offset`, remain IDLE.
  - Otherwise: latch the size, stack and new-stack flags and count. Set `offset_reg` = dec(`start_offset`), `push_index` = 0, go to CHECK.
- **CHECK** (exactly one cycle):
  - Assert the selected fault-check strobe: new when `start_new_stack` was latched, else old.
  - Selected fault high: pulse `fault`, go to IDLE, leave `final_offset` unchanged, issue no write.
  - Otherwise: latch the selected linear address and `push_data` into the write registers and go to WRITE.
- **WRITE**:
  - `mem_write_do`=1 with stable address, data and length until `mem_write_done`.
  - On done with `push_index`==count−1: pulse `done`, set `final_offset` = `offset_reg`, go to IDLE.
  - On done otherwise: increment `push_index`, set `offset_reg` = dec(`offset_reg`), go to CHECK.
- Push order: index 0 is written first, at the highest address.

Abort handling:
- `abort` in CHECK: go to IDLE next cycle; no `done`, no `fault`, no write.
- `abort` in WRITE: sticky. The outstanding write completes, then the block goes to IDLE with no `done`.

Other rules:
- `start` while busy is ignored.
- `stack_offset` = `offset_reg` in all states, so the stack-check block always sees the current push.

## Timing
- Reset values: state IDLE, `mem_write_do`=0, `done`=0, `fault`=0, `busy`=0, `push_index`=0, `offset_reg`=0, `final_offset`=0, both fault-check strobes 0, `push_length_dword`=1, `push_length_word`=0, write registers 0.
- Reset mid-sequence drops `mem_write_do` in the next cycle; the memory side tolerates this.
- `start` at cycle T: CHECK at T+1, `mem_write_do` first high at T+2.
- `mem_write_done` may be high in the first WRITE cycle.
- Minimum two cycles per push. For N pushes with zero-wait memory, `done` pulses at T+2N+1, concurrent with state IDLE.
- Fault inputs are sampled combinationally in CHECK only; their values in other states are don't-care.
- `done`, `fault` and abort exit are mutually exclusive. Abort wins over a fault in the same CHECK cycle.

## Test plan
- 32-bit stack, dword pushes, `start_offset`=0x00001000, count=3, ss_base 0, data 0xA/0xB/0xC, zero-wait memory → writes (0xFFC,0xA), (0xFF8,0xB), (0xFF4,0xC), each length 4. `done` at T+7, `final_offset`=0x00000FF4.
- 16-bit stack, word pushes, `start_offset`=0xABCD0001, count=2 → offsets 0xABCDFFFF then 0xABCDFFFD, `final_offset`=0xABCDFFFD, length 2.
- `push_ss_fault` high only on the second CHECK, count=4 → exactly one write, `fault` pulse, no `done`, `final_offset` retains its prior value.
- `start_new_stack`=1 with `new_push_ss_fault`=1 and `push_ss_fault`=0 → `fault` pulse, no write, only `new_push_ss_fault_check` asserted.
- 5-cycle memory wait, `abort` in the second wait cycle of push 0 (count=3) → `mem_write_do` held until done, then IDLE. No further writes, no `done`.
- count=0 → `done` at T+1, no writes. `start` pulsed while busy is ignored. `rst` asserted during WRITE → next cycle IDLE, `mem_write_do`=0, `busy`=0.

Source files
------------

// File: rtl/write_push_sequencer.sv
// write_push_sequencer: walks the stack offset down one push at a time, checks each push
// through the stack-check block and issues one memory write per push.
module write_push_sequencer #(
  parameter int MAX_PUSH = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  start_count,
  input  logic [31:0] start_offset,
  input  logic        start_size_16,
  input  logic        start_stack_32,
  input  logic        start_new_stack,
  input  logic        abort,
  output logic [2:0]  push_index,
  input  logic [31:0] push_data,
  output logic [31:0] stack_offset,
  output logic        push_length_word,
  output logic        push_length_dword,
  output logic        push_ss_fault_check,
  output logic        new_push_ss_fault_check,
  input  logic [31:0] push_linear,
  input  logic [31:0] new_push_linear,
  input  logic        push_ss_fault,
  input  logic        new_push_ss_fault,
  output logic        mem_write_do,
  output logic [31:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic [2:0]  mem_write_length,
  input  logic        mem_write_done,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] final_offset
);
  typedef enum logic [1:0] {IDLE, CHECK, WRITE} state_t;
  localparam logic [2:0] MAX_CNT = 3'(MAX_PUSH);
  state_t state, state_nx;
  logic [31:0] offset_reg, wr_addr, wr_data, sel_linear;
  logic [2:0] count_reg, cnt;
  logic size_16, stack_32, new_stack, abort_pend, sel_fault, last;
  // A 16-bit stack only wraps the low half of the offset; the high half rides along unchanged.
  function automatic logic [31:0] dec(input logic [31:0] x, input logic s16, input logic s32);
    logic [15:0] len;
    len = s16 ? 16'd2 : 16'd4;
    return s32 ? x - {16'd0, len} : {x[31:16], x[15:0] - len};
  endfunction
  assign cnt = (start_count > MAX_CNT) ? MAX_CNT : start_count;
  assign sel_fault = new_stack ? new_push_ss_fault : push_ss_fault;
  assign sel_linear = new_stack ? new_push_linear : push_linear;
  assign last = push_index == count_reg - 3'd1;
  assign stack_offset = offset_reg;
  assign push_length_word = size_16;
  assign push_length_dword = !size_16;
  assign mem_write_address = wr_addr;
  assign mem_write_data = wr_data;
  assign mem_write_length = size_16 ? 3'd2 : 3'd4;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (start && cnt != 3'd0) ? CHECK : IDLE;
      CHECK:   state_nx = (abort || sel_fault) ? IDLE : WRITE;
      WRITE:   state_nx = !mem_write_done ? WRITE : (abort_pend || abort || last) ? IDLE : CHECK;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    mem_write_do = state == WRITE;
    push_ss_fault_check = state == CHECK && !new_stack;
    new_push_ss_fault_check = state == CHECK && new_stack;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      offset_reg <= '0;
      final_offset <= '0;
      push_index <= '0;
      count_reg <= '0;
      size_16 <= 1'b0;
      stack_32 <= 1'b0;
      new_stack <= 1'b0;
      abort_pend <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      done <= 1'b0;
      fault <= 1'b0;
    end else begin
      done <= 1'b0;
      fault <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (cnt == 3'd0) begin
            done <= 1'b1;
            final_offset <= start_offset;
          end else begin
            size_16 <= start_size_16;
            stack_32 <= start_stack_32;
            new_stack <= start_new_stack;
            count_reg <= cnt;
            abort_pend <= 1'b0;
            push_index <= '0;
            offset_reg <= dec(start_offset, start_size_16, start_stack_32);
          end
        end
        CHECK: if (!abort) begin
          if (sel_fault) fault <= 1'b1;
          else begin
            wr_addr <= sel_linear;
            wr_data <= push_data;
          end
        end
        WRITE: begin
          // An abort during a write lets that write finish but suppresses everything after it.
          abort_pend <= abort_pend | abort;
          if (mem_write_done && !abort_pend && !abort) begin
            if (last) begin
              done <= 1'b1;
              final_offset <= offset_reg;
            end else begin
              push_index <= push_index + 3'd1;
              offset_reg <= dec(offset_reg, size_16, stack_32);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_write_push_sequencer.sv
// tb_write_push_sequencer: directed sequences checked against a push-list model and memory scoreboard.
module tb_write_push_sequencer;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  logic start = 0, start_size_16 = 0, start_stack_32 = 1, start_new_stack = 0, abort = 0;
  logic [2:0] start_count = 0;
  logic [31:0] start_offset = 0;
  logic [2:0] push_index, mem_write_length;
  logic [31:0] push_data, stack_offset, push_linear, new_push_linear;
  logic [31:0] mem_write_address, mem_write_data, final_offset;
  logic push_length_word, push_length_dword, push_ss_fault_check, new_push_ss_fault_check;
  logic push_ss_fault, new_push_ss_fault, mem_write_do, mem_write_done, busy, done, fault;
  logic [31:0] ss_base = 0, new_base = 0;
  logic [31:0] data_tab [0:7];
  logic old_f_en = 0, new_f_en = 0;
  int old_f_idx = 0, new_f_idx = 0;
  write_push_sequencer #(.MAX_PUSH(6)) dut (
    .clk(clk), .rst(rst), .start(start), .start_count(start_count), .start_offset(start_offset),
    .start_size_16(start_size_16), .start_stack_32(start_stack_32), .start_new_stack(start_new_stack),
    .abort(abort), .push_index(push_index), .push_data(push_data), .stack_offset(stack_offset),
    .push_length_word(push_length_word), .push_length_dword(push_length_dword),
    .push_ss_fault_check(push_ss_fault_check), .new_push_ss_fault_check(new_push_ss_fault_check),
    .push_linear(push_linear), .new_push_linear(new_push_linear), .push_ss_fault(push_ss_fault),
    .new_push_ss_fault(new_push_ss_fault), .mem_write_do(mem_write_do),
    .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
    .mem_write_length(mem_write_length), .mem_write_done(mem_write_done), .busy(busy),
    .done(done), .fault(fault), .final_offset(final_offset)
  );
  // Stand-in for the stack-check block and the push-data requester.
  assign push_linear = ss_base + stack_offset;
  assign new_push_linear = new_base + stack_offset;
  assign push_ss_fault = old_f_en && (32'(push_index) == old_f_idx);
  assign new_push_ss_fault = new_f_en && (32'(push_index) == new_f_idx);
  assign push_data = data_tab[push_index];
  typedef struct {logic [31:0] addr; logic [31:0] data; logic [2:0] len;} wr_t;
  wr_t exp_q[$];
  int checks = 0, failures = 0;
  int cyc = 0;
  int t0 = 0, mem_wait = 0, wcnt = 0;
  int done_cnt = 0, fault_cnt = 0, wr_seen = 0, old_seen = 0, new_seen = 0, done_cyc = -1;
  logic [31:0] prev_final = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Memory responder and per-cycle compare against the expected write list.
  initial begin
    mem_write_done = 0;
    forever begin
      @(negedge clk);
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (fault) fault_cnt++;
      if (push_ss_fault_check) old_seen++;
      if (new_push_ss_fault_check) new_seen++;
      if (!rst) chk("len_onehot", 32'(push_length_word ^ push_length_dword), 1);
      if (!rst && busy && !mem_write_do)
        chk("one_strobe", 32'(push_ss_fault_check) + 32'(new_push_ss_fault_check), 1);
      if (mem_write_do) begin
        wcnt++;
        mem_write_done = wcnt > mem_wait;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=%h required=none", mem_write_address);
        end else begin
          chk("wr_addr", mem_write_address, exp_q[0].addr);
          chk("wr_data", mem_write_data, exp_q[0].data);
          chk("wr_len", 32'(mem_write_length), 32'(exp_q[0].len));
          if (mem_write_done) begin
            void'(exp_q.pop_front());
            wr_seen++;
          end
        end
      end else begin
        wcnt = 0;
        mem_write_done = 0;
      end
    end
  end
  // keep >= 0: that many pushes finish before the abort takes effect.
  task automatic run_seq(input logic [2:0] cnt, input logic [31:0] off, input logic s16,
                         input logic s32, input logic ns, input int ab_at, input int rs_at,
                         input int keep);
    logic [31:0] ofs;
    int n, len, nexp;
    logic exp_fault, exp_done, timed_out;
    ofs = off;
    len = s16 ? 2 : 4;
    n = (cnt > 3'd6) ? 6 : int'(cnt);
    exp_fault = 0;
    for (int k = 0; k < n; k++) begin
      if (keep >= 0 && k >= keep) break;
      ofs = s32 ? ofs - 32'(len) : {ofs[31:16], 16'(ofs[15:0] - 16'(len))};
      if (ns ? (new_f_en && new_f_idx == k) : (old_f_en && old_f_idx == k)) begin
        exp_fault = 1;
        break;
      end
      exp_q.push_back('{addr: (ns ? new_base : ss_base) + ofs, data: data_tab[k], len: 3'(len)});
    end
    nexp = exp_q.size();
    exp_done = !exp_fault && keep < 0;
    if (exp_done) prev_final = ofs;
    @(negedge clk);
    start_count = cnt; start_offset = off; start_size_16 = s16;
    start_stack_32 = s32; start_new_stack = ns; start = 1;
    t0 = cyc;
    done_cnt = 0; fault_cnt = 0; wr_seen = 0; old_seen = 0; new_seen = 0; done_cyc = -1;
    timed_out = 1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      start = (i == rs_at);
      abort = (i == ab_at);
      if (!busy && i > 1) begin
        timed_out = 0;
        break;
      end
      if (!busy && cnt == 3'd0) begin
        timed_out = 0;
        break;
      end
    end
    start = 0;
    abort = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("seq_timeout", 32'(timed_out), 0);
    chk("done_cnt", 32'(done_cnt), 32'(exp_done));
    chk("fault_cnt", 32'(fault_cnt), 32'(exp_fault));
    chk("writes", 32'(wr_seen), 32'(nexp));
    chk("final_offset", final_offset, prev_final);
    if (exp_done && mem_wait == 0) chk("done_time", 32'(done_cyc - t0), 32'(2 * n + 1));
    exp_q.delete();
  endtask
  initial begin
    for (int i = 0; i < 8; i++) data_tab[i] = 32'hD000_0000 + 32'(i);
    data_tab[0] = 32'hA; data_tab[1] = 32'hB; data_tab[2] = 32'hC;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_do", 32'(mem_write_do), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_index", 32'(push_index), 0);
    chk("rst_offset", stack_offset, 0);
    chk("rst_final", final_offset, 0);
    chk("rst_dword", 32'(push_length_dword), 1);
    chk("rst_word", 32'(push_length_word), 0);
    chk("rst_strobes", 32'({push_ss_fault_check, new_push_ss_fault_check}), 0);
    chk("rst_addr", mem_write_address, 0);
    chk("rst_data", mem_write_data, 0);
    rst = 0;
    // 32-bit stack, dword pushes, three zero-wait writes
    run_seq(3'd3, 32'h0000_1000, 0, 1, 0, -1, -1, -1);
    chk("t1_final_lit", final_offset, 32'h0000_0FF4);
    chk("t1_model_lit", prev_final, 32'h0000_0FF4);
    chk("t1_done_t7", 32'(done_cyc - t0), 7);
    // 16-bit stack, word pushes, new stack; start repulsed while busy
    new_base = 32'h0002_0000; ss_base = 32'h0003_0000;
    run_seq(3'd2, 32'hABCD_0001, 1, 0, 1, -1, 2, -1);
    chk("t2_final_lit", final_offset, 32'hABCD_FFFD);
    // old-stack fault on the second check
    old_f_en = 1; old_f_idx = 1;
    run_seq(3'd4, 32'h0000_2000, 0, 1, 0, -1, -1, -1);
    chk("t3_final_kept", final_offset, 32'hABCD_FFFD);
    // new-stack fault on the first check; old fault input stays low
    old_f_en = 0; new_f_en = 1; new_f_idx = 0;
    run_seq(3'd2, 32'h0000_3000, 0, 1, 1, -1, -1, -1);
    chk("t4_old_strobe", 32'(old_seen), 0);
    chk("t4_new_strobe", 32'(new_seen), 1);
    new_f_en = 0;
    // abort in the second wait cycle of push 0
    mem_wait = 5;
    run_seq(3'd3, 32'h0000_4000, 0, 1, 0, 3, -1, 1);
    // abort in CHECK
    mem_wait = 0;
    run_seq(3'd2, 32'h0000_5000, 0, 1, 0, 1, -1, 0);
    // zero pushes
    run_seq(3'd0, 32'h1234_5678, 0, 1, 0, -1, -1, -1);
    chk("t7_done_t1", 32'(done_cyc - t0), 1);
    chk("t7_final_lit", final_offset, 32'h1234_5678);
    // count clamped to six with 16-bit offset wrap
    ss_base = 0;
    run_seq(3'd7, 32'h0000_0010, 0, 0, 0, -1, -1, -1);
    chk("t8_final_lit", final_offset, 32'h0000_FFF8);
    // reset while a write is outstanding
    mem_wait = 5;
    exp_q.push_back('{addr: 32'h0000_0FFC, data: 32'hA, len: 3'd4});
    @(negedge clk);
    start_count = 3'd3; start_offset = 32'h0000_1000; start_size_16 = 0;
    start_stack_32 = 1; start_new_stack = 0; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    chk("t9_in_write", 32'(mem_write_do), 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("t9_do_low", 32'(mem_write_do), 0);
    chk("t9_busy_low", 32'(busy), 0);
    chk("t9_final_rst", final_offset, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
